instr_fetch_ctrl: RTL

Sequencer that owns the program counter for the 8-bit instruction memory. It drives the memory's address and captures the combinational read data into a single-entry output register. It hands each instruction to the decode stage over a valid/ready handshake. It also handles start, redirect (branch/jump), end-of-program and a delivered-instruction count.

---
 rtl/instr_fetch_ctrl.sv | 116 +++++++++++
 1 files changed

// File: rtl/instr_fetch_ctrl.sv
// instr_fetch_ctrl: PC sequencer feeding decode over valid/ready with redirect and delivery count.
// Define IFETCH_WRAP_EN to loop the program instead of draining to DONE.
module instr_fetch_ctrl #(
    parameter int unsigned       ADDR_W     = 8,
    parameter int unsigned       DATA_W     = 8,
    parameter logic [ADDR_W-1:0] RESET_PC   = 8'd0,
    parameter int unsigned       PROG_DEPTH = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic [ADDR_W-1:0] instruction_address,
    input  logic [DATA_W-1:0] instruction_data,
    output logic              inst_valid,
    output logic [DATA_W-1:0] inst_data,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              inst_ready,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [7:0]        fetch_count
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST_PC = RESET_PC + ADDR_W'(PROG_DEPTH - 1);

    state_t            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] inst_pc_q;
    logic [DATA_W-1:0] inst_data_q;
    logic              inst_valid_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;
    logic [7:0]        fetch_count_q;
    logic [ADDR_W-1:0] rel;
    logic              hs;
    logic              slot_free;
    logic              at_last;
    logic              in_range;

    assign hs        = inst_valid_q && inst_ready;
    assign slot_free = !inst_valid_q || inst_ready;
    assign at_last   = pc_q == LAST_PC;
    assign rel       = redirect_addr - RESET_PC;
    assign in_range  = {1'b0, rel} < (ADDR_W + 1)'(PROG_DEPTH);
`ifdef IFETCH_WRAP_EN
    assign pc_d = at_last ? RESET_PC : pc_q + ADDR_W'(1);
`else
    // PC parks on the last word; DRAIN/DONE never fetch again
    assign pc_d = at_last ? pc_q : pc_q + ADDR_W'(1);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            inst_valid_q  <= 1'b0;
            inst_data_q   <= '0;
            inst_pc_q     <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            fetch_count_q <= '0;
        end else begin
            if (hs && fetch_count_q != 8'hFF) fetch_count_q <= fetch_count_q + 8'd1;
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q       <= RUN;
                        pc_q          <= RESET_PC;
                        err_q         <= 1'b0;
                        fetch_count_q <= '0;
                        busy_q        <= 1'b1;
                        done_q        <= 1'b0;
                    end
                end
                RUN, DRAIN: begin
                    if (redirect_valid && in_range) begin
                        state_q      <= RUN;
                        pc_q         <= redirect_addr;
                        inst_valid_q <= 1'b0;
                    end else begin
                        if (redirect_valid) err_q <= 1'b1;
                        if (slot_free && state_q == RUN) begin
                            inst_data_q  <= instruction_data;
                            inst_pc_q    <= pc_q;
                            inst_valid_q <= 1'b1;
                            pc_q         <= pc_d;
`ifndef IFETCH_WRAP_EN
                            if (at_last) state_q <= DRAIN;
`endif
                        end else if (slot_free) begin
                            inst_valid_q <= 1'b0;
                            state_q      <= DONE;
                            busy_q       <= 1'b0;
                            done_q       <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign instruction_address = pc_q;
    assign inst_valid          = inst_valid_q;
    assign inst_data           = inst_data_q;
    assign inst_pc             = inst_pc_q;
    assign busy                = busy_q;
    assign done                = done_q;
    assign err                 = err_q;
    assign fetch_count         = fetch_count_q;
endmodule
